mac_sequencer: RTL

- Controller ahead of the MAC pipeline-register stage.
- Accepts a job command (length, signed mode, clear-first), pulls operand pairs over a valid/ready stream, and issues them to the pipeline as registered a/b/valid/clear/signed signals.
- Waits a fixed drain time so the last product can settle in the accumulator, then signals completion.
- Sits between the tt_um top-level I/O decode and the MAC datapath.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_sequencer_if.sv | 25 ++
 rtl/mac_seq_counter.sv | 26 ++
 rtl/mac_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC sequencer slice.
package mac_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int LEN_W_DEF        = 8;
  // Matches the depth of the MAC pipeline behind the sequencer.
  localparam int DRAIN_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// Operand stream in and pipeline issue out, bundled for the sequencer.
// slave: the sequencer side. master: the upstream source / pipeline side.
interface mac_sequencer_if #(
  parameter int DATA_W = mac_pkg::DATA_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] pipe_a;
  logic [DATA_W-1:0] pipe_b;
  logic              pipe_valid;
  logic              pipe_clear;
  logic              pipe_signed;

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, pipe_a, pipe_b, pipe_valid, pipe_clear, pipe_signed
  );

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, pipe_a, pipe_b, pipe_valid, pipe_clear, pipe_signed
  );
endinterface

// File: rtl/mac_seq_counter.sv
// Loadable down-counter with zero flag; stops at zero instead of wrapping.
// Priority: clr > load > dec.
module mac_seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  // count register
  always_ff @(posedge clk) begin
    if (!rst_n)                   count <= '0;
    else if (clr)                 count <= '0;
    else if (load)                count <= load_val;
    else if (dec && count != '0)  count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mac_sequencer.sv
// Job sequencer in front of the MAC pipeline-register stage.
// Optional abort support is enabled with the MAC_SEQUENCER_ABORT_EN macro.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; in_ready low
// ST_RUN   | accepting operand pairs, one issue per handshake
// ST_DRAIN | last pair issued, waiting for it to reach the accumulator
// ST_DONE  | one-cycle done pulse, then back to idle
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int LEN_W        = LEN_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_signed,
  input  logic             cfg_clear,
`ifdef MAC_SEQUENCER_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] remaining,
  mac_sequencer_if.slave   bus
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

  seq_state_t state, state_nxt;

  logic               ready;
  logic               job_load;
  logic               issue;
  logic               rem_dec;
  logic               drain_load;
  logic               drain_dec;
  logic               cnt_clr;
  logic               abort_req;
  logic               rem_zero;
  logic               rem_last;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               drain_zero;

  logic [DATA_W-1:0]  pipe_a;
  logic [DATA_W-1:0]  pipe_b;
  logic               pipe_valid;
  logic               pipe_clear;
  logic               pipe_signed;
  logic               first_pending;
  logic               clear_lat;

`ifdef MAC_SEQUENCER_ABORT_EN
  assign abort_req = abort && (state == ST_RUN || state == ST_DRAIN);
`else
  assign abort_req = 1'b0;
`endif

  assign rem_last = (remaining == LEN_W'(1));

  mac_seq_counter #(.W(LEN_W)) u_rem_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (job_load),
    .dec      (rem_dec),
    .load_val (cfg_len),
    .count    (remaining),
    .zero     (rem_zero)
  );

  mac_seq_counter #(.W(DRAIN_W)) u_drain_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (drain_load),
    .dec      (drain_dec),
    .load_val (DRAIN_W'(DRAIN_CYCLES - 1)),
    .count    (drain_cnt),
    .zero     (drain_zero)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next-state decode and per-cycle control strobes
  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    job_load   = 1'b0;
    issue      = 1'b0;
    rem_dec    = 1'b0;
    drain_load = 1'b0;
    drain_dec  = 1'b0;
    cnt_clr    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            job_load  = 1'b1;
            state_nxt = ST_RUN;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        ready = 1'b1;
        // rem_zero cannot be set in RUN; the guard keeps remaining from underflowing
        if (bus.in_valid && !rem_zero) begin
          issue   = 1'b1;
          rem_dec = 1'b1;
          if (rem_last) begin
            drain_load = 1'b1;
            state_nxt  = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_zero) state_nxt = ST_DONE;
        else            drain_dec = 1'b1;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // abort wins over a same-cycle handshake, which is simply dropped
    if (abort_req) begin
      state_nxt  = ST_IDLE;
      cnt_clr    = 1'b1;
      issue      = 1'b0;
      rem_dec    = 1'b0;
      drain_load = 1'b0;
      drain_dec  = 1'b0;
    end
  end

  // pipeline issue registers and per-job latched config
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_a        <= '0;
      pipe_b        <= '0;
      pipe_valid    <= 1'b0;
      pipe_clear    <= 1'b0;
      pipe_signed   <= 1'b0;
      first_pending <= 1'b0;
      clear_lat     <= 1'b0;
    end else begin
      pipe_valid <= issue;
      pipe_clear <= issue && first_pending && clear_lat;
      if (issue) begin
        pipe_a        <= bus.in_a;
        pipe_b        <= bus.in_b;
        first_pending <= 1'b0;
      end
      if (job_load) begin
        pipe_signed   <= cfg_signed;
        clear_lat     <= cfg_clear;
        first_pending <= 1'b1;
      end
    end
  end

`ifdef MAC_SEQUENCER_ABORT_EN
  // one-cycle aborted pulse following an accepted abort
  always_ff @(posedge clk) begin
    if (!rst_n) aborted <= 1'b0;
    else        aborted <= abort_req;
  end
`endif

  assign bus.in_ready    = ready;
  assign bus.pipe_a      = pipe_a;
  assign bus.pipe_b      = pipe_b;
  assign bus.pipe_valid  = pipe_valid;
  assign bus.pipe_clear  = pipe_clear;
  assign bus.pipe_signed = pipe_signed;

endmodule
